// File: rtl/button_bit_encoder_pkg.sv
// Shared constants and types for the two-button serial-bit encoder.
// Holds the debounce default, counter sizing and the bit value names.
package button_bit_encoder_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 4;

    localparam logic BIT_ONE  = 1'b1;
    localparam logic BIT_ZERO = 1'b0;

    // Debounce counter must be able to represent DEBOUNCE_CYCLES itself.
    function automatic int db_cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

    localparam int DB_CNT_W_DEF = db_cnt_width(DEBOUNCE_CYCLES_DEF);

    typedef enum logic [1:0] {
        ARB_NONE,
        ARB_ONE,
        ARB_ZERO,
        ARB_CONFLICT
    } arb_e;

endpackage

// File: rtl/btn_debounce.sv
// One button path: 2-flop synchroniser, debounce counter, stable level and a
// registered single-cycle press pulse on each accepted 0->1 transition.
module btn_debounce
    import button_bit_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_stable,
    output logic o_press
);

    localparam int              DB_W     = db_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] LAST_CNT = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_stable;
    logic            r_press;
    logic [DB_W-1:0] r_cnt;

    logic w_differ;
    logic w_accept;

    assign w_differ = (r_sync2 != r_stable);
    // The increment that would reach DEBOUNCE_CYCLES is the accepting cycle.
    assign w_accept = w_differ && (r_cnt == LAST_CNT);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; the synchroniser chain depends on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= w_accept && r_sync2;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt    <= '0;
                r_stable <= r_sync2;
            end else begin
                r_cnt <= r_cnt + DB_W'(1);
            end
        end
    end

    assign o_stable = r_stable;
    assign o_press  = r_press;

endmodule

// File: rtl/button_bit_encoder.sv
// Turns two debounced buttons into single-cycle bit events for the pattern
// detector, rejecting overlapping presses and counting accepted bits.
module button_bit_encoder
    import button_bit_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_one,
    input  logic             btn_zero,
    output logic             bit_valid,
    output logic             bit_data,
    output logic             conflict,
    output logic [CNT_W-1:0] bit_count
);

    logic w_stable_one;
    logic w_press_one;
    logic w_stable_zero;
    logic w_press_zero;
    arb_e w_arb;

    logic             r_bit_valid;
    logic             r_bit_data;
    logic             r_conflict;
    logic [CNT_W-1:0] r_bit_count;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_one (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_btn    (btn_one),
        .o_stable (w_stable_one),
        .o_press  (w_press_one)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_zero (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_btn    (btn_zero),
        .o_stable (w_stable_zero),
        .o_press  (w_press_zero)
    );

    // NOTE: w_arb gets a default before any branch so no latch is inferred.
    always_comb begin
        w_arb = ARB_NONE;
        if (w_press_one && w_press_zero) begin
            w_arb = ARB_CONFLICT;
        end else if (w_press_one) begin
            w_arb = w_stable_zero ? ARB_CONFLICT : ARB_ONE;
        end else if (w_press_zero) begin
            w_arb = w_stable_one ? ARB_CONFLICT : ARB_ZERO;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_valid <= 1'b0;
            r_bit_data  <= BIT_ZERO;
            r_conflict  <= 1'b0;
            r_bit_count <= '0;
        end else begin
            r_bit_valid <= (w_arb == ARB_ONE) || (w_arb == ARB_ZERO);
            r_conflict  <= (w_arb == ARB_CONFLICT);
            if (w_arb == ARB_ONE) begin
                r_bit_data <= BIT_ONE;
            end else if (w_arb == ARB_ZERO) begin
                r_bit_data <= BIT_ZERO;
            end
            // Wraps freely; consumers only care about the count modulo 2**CNT_W.
            if ((w_arb == ARB_ONE) || (w_arb == ARB_ZERO)) begin
                r_bit_count <= r_bit_count + CNT_W'(1);
            end
        end
    end

    assign bit_valid = r_bit_valid;
    assign bit_data  = r_bit_data;
    assign conflict  = r_conflict;
    assign bit_count = r_bit_count;

endmodule

// File: tb/tb_button_bit_encoder.sv
// Directed bench for button_bit_encoder: latency, bounce rejection, conflicts,
// reset mid-debounce and bit_count wrap. Inputs driven and outputs sampled on negedge.
module tb_button_bit_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_one = 1'b0;
    logic       btn_zero = 1'b0;
    logic       bit_valid;
    logic       bit_data;
    logic       conflict;
    logic [7:0] bit_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_count = 0;

    int   lat;
    logic ev_valid;
    logic ev_conf;
    logic ev_data;

    button_bit_encoder #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_one   (btn_one),
        .btn_zero  (btn_zero),
        .bit_valid (bit_valid),
        .bit_data  (bit_data),
        .conflict  (conflict),
        .bit_count (bit_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called right after driving an input on a negedge; k counts negedges after
    // the first posedge that samples that input.
    task automatic wait_bit(output int l, output logic v, output logic c, output logic d);
        l = -1;
        v = 1'b0;
        c = 1'b0;
        d = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bit_valid || conflict) begin
                l = k;
                v = bit_valid;
                c = conflict;
                d = bit_data;
                break;
            end
        end
    endtask

    task automatic quiet(input string tag, input int n);
        int ev = 0;
        repeat (n) begin
            @(negedge clk);
            if (bit_valid || conflict) ev++;
        end
        check(tag, ev, 0);
    endtask

    function automatic logic pat(input int i);
        if (i < 4) return (i != 1);
        return (i % 2 == 0);
    endfunction

    initial begin
        int   bad;
        logic b;
        logic first4 [4];

        repeat (3) @(negedge clk);
        check("reset_valid", bit_valid, 0);
        check("reset_data", bit_data, 0);
        check("reset_conflict", conflict, 0);
        check("reset_count", bit_count, 0);
        rst_n = 1'b1;
        quiet("idle", 5);

        // 1: clean press of btn_one, nothing more while held or on release
        btn_one = 1'b1;
        wait_bit(lat, ev_valid, ev_conf, ev_data);
        check("t1_latency", lat, 6);
        check("t1_valid", ev_valid, 1);
        check("t1_data", ev_data, 1);
        check("t1_conflict", ev_conf, 0);
        exp_count++;
        check("t1_count", bit_count, exp_count);
        quiet("t1_hold", 10);
        btn_one = 1'b0;
        quiet("t1_release", 12);

        // 2: bounces on btn_zero, then a hold
        btn_zero = 1'b1; @(negedge clk);
        btn_zero = 1'b0; @(negedge clk);
        btn_zero = 1'b1; @(negedge clk);
        btn_zero = 1'b0; @(negedge clk);
        btn_zero = 1'b1;
        wait_bit(lat, ev_valid, ev_conf, ev_data);
        check("t2_latency", lat, 6);
        check("t2_valid", ev_valid, 1);
        check("t2_data", ev_data, 0);
        exp_count++;
        check("t2_count", bit_count, exp_count);
        quiet("t2_hold", 10);
        btn_zero = 1'b0;
        quiet("t2_release", 12);

        // 3: simultaneous presses
        btn_one  = 1'b1;
        btn_zero = 1'b1;
        wait_bit(lat, ev_valid, ev_conf, ev_data);
        check("t3_latency", lat, 6);
        check("t3_conflict", ev_conf, 1);
        check("t3_valid", ev_valid, 0);
        quiet("t3_hold", 10);
        check("t3_count", bit_count, exp_count);
        btn_one  = 1'b0;
        btn_zero = 1'b0;
        quiet("t3_release", 12);

        // 4: press while the other button is stable-pressed, then a clean press
        btn_zero = 1'b1;
        wait_bit(lat, ev_valid, ev_conf, ev_data);
        check("t4_zero_valid", ev_valid, 1);
        check("t4_zero_data", ev_data, 0);
        exp_count++;
        quiet("t4_zero_hold", 4);
        btn_one = 1'b1;
        wait_bit(lat, ev_valid, ev_conf, ev_data);
        check("t4_conf_latency", lat, 6);
        check("t4_conflict", ev_conf, 1);
        check("t4_conf_valid", ev_valid, 0);
        check("t4_conf_count", bit_count, exp_count);
        btn_one  = 1'b0;
        btn_zero = 1'b0;
        quiet("t4_release", 12);
        btn_one = 1'b1;
        wait_bit(lat, ev_valid, ev_conf, ev_data);
        check("t4_one_valid", ev_valid, 1);
        check("t4_one_data", ev_data, 1);
        exp_count++;
        check("t4_count", bit_count, exp_count);
        btn_one = 1'b0;
        quiet("t4_one_release", 12);

        // 6: reset in the middle of a debounce with the button still held
        btn_one = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_count_now", bit_count, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_rst_valid", bit_valid, 0);
            check("t6_rst_conflict", conflict, 0);
            check("t6_rst_count", bit_count, 0);
        end
        rst_n = 1'b1;
        wait_bit(lat, ev_valid, ev_conf, ev_data);
        check("t6_latency", lat, 6);
        check("t6_valid", ev_valid, 1);
        check("t6_data", ev_data, 1);
        check("t6_count", bit_count, 1);
        btn_one = 1'b0;
        quiet("t6_release", 12);

        // 5: 256 presses from a fresh reset, count wraps back to 0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_start_count", bit_count, 0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            b = pat(i);
            if (b) btn_one = 1'b1;
            else   btn_zero = 1'b1;
            wait_bit(lat, ev_valid, ev_conf, ev_data);
            if (!(ev_valid === 1'b1 && ev_conf === 1'b0 && lat == 6 && ev_data === b)) bad++;
            if (i < 4) first4[i] = ev_data;
            if (i == 254) check("t5_count_255", bit_count, 255);
            btn_one  = 1'b0;
            btn_zero = 1'b0;
            repeat (8) @(negedge clk);
        end
        check("t5_bad_events", bad, 0);
        check("t5_seq0", first4[0], 1);
        check("t5_seq1", first4[1], 0);
        check("t5_seq2", first4[2], 1);
        check("t5_seq3", first4[3], 1);
        check("t5_count_wrap", bit_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
